// File: rtl/uart_host_pkg.sv
// Shared types and constants for the host-side UART transmitter.
// Parity-related items are used only when UART_HOST_PARITY_EN is defined.
package uart_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic int unsigned clks_per_bit(input int unsigned sys_clk_freq,
                                               input int unsigned baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_host_tx_if.sv
// Host push/status bundle of uart_host_tx: the harness drives the master side,
// the transmitter implements the slave side.
interface uart_host_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       tx_done;
  logic       overflow;

  modport master (
    output wr_en, wr_data,
    input  full, empty, busy, tx_done, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, busy, tx_done, overflow
  );
endinterface

// File: rtl/uart_host_fifo.sv
// 8-bit synchronous FIFO, 2^DEPTH_LOG2 entries, first-word fall-through read.
// Pointers carry one extra wrap bit so full/empty come from a plain compare.
module uart_host_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr;
  logic [DEPTH_LOG2:0] rptr;
  logic                do_push;
  logic                do_pop;

  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign empty = (wptr == rptr);

  // full is judged before this edge's pop, so push+pop while full drops the push
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (push && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= push_data;
  end

  assign pop_data = mem[rptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter feeding riscv_top.Rx: FIFO-buffered 8N1 frames,
// or 8E1 when UART_HOST_PARITY_EN is defined.
module uart_host_tx
  import uart_host_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ    = 100000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_host_tx_if.slave        bus,
  output logic                 tx
);

  localparam int unsigned CPB      = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW       = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          pop;
  logic          bit_end;
  logic          tx_n;
  logic          done;
  logic          busy_c;
  logic [7:0]    fifo_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
`ifdef UART_HOST_PARITY_EN
  logic          par, par_n;
`endif

  uart_host_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.wr_en),
    .push_data(bus.wr_data),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= IDLE_LEVEL;
`ifdef UART_HOST_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
`ifdef UART_HOST_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
`ifdef UART_HOST_PARITY_EN
    par_n   = par;
`endif
    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

    case (state)
      IDLE:  if (!fifo_empty) pop = 1'b1;
      START: if (bit_end) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA:  if (bit_end) begin
        shift_n = shift >> 1;
        idx_n   = idx + 1'b1;
`ifdef UART_HOST_PARITY_EN
        if (idx == 3'd7) state_n = PARITY;
`else
        if (idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_HOST_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP:  if (bit_end) begin
        if (!fifo_empty) pop = 1'b1;
        else             state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // IDLE and end-of-STOP share the load so frames run back to back
    if (pop) begin
      shift_n = fifo_data;
      state_n = START;
      cnt_n   = '0;
`ifdef UART_HOST_PARITY_EN
      par_n   = ^fifo_data;
`endif
    end
  end

  // tx is registered from next-state values, so it changes on the same edge as the state
  always_comb begin
    case (state_n)
      START:   tx_n = START_LEVEL;
      DATA:    tx_n = shift_n[0];
`ifdef UART_HOST_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = IDLE_LEVEL;
    endcase
    done   = (state == STOP) && bit_end;
    busy_c = (state != IDLE) || !fifo_empty;
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.overflow = fifo_ovf;
  assign bus.tx_done  = done;
  assign bus.busy     = busy_c;

endmodule
